// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the RV32I multi-cycle CPU.
// Produces the datapath enables, the operand and next-PC mux selects, a halt flag and a retired-instruction count.
module mc_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        bcond,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        retire,
  output logic        is_halted,
  output logic [31:0] inst_count
);

  typedef enum logic [3:0] {
    ST_IF       = 4'd0,
    ST_ID       = 4'd1,
    ST_EX_R     = 4'd2,
    ST_EX_I     = 4'd3,
    ST_EX_ADDR  = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_ALU   = 4'd7,
    ST_WB_LD    = 4'd8,
    ST_EX_BR    = 4'd9,
    ST_BR_T     = 4'd10,
    ST_PC4      = 4'd11,
    ST_EX_JAL   = 4'd12,
    ST_EX_JALR  = 4'd13,
    ST_EX_ECALL = 4'd14,
    ST_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] ALUOP_ITYP = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IF;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IF: state_next = ST_ID;
      ST_ID: begin
        case (opcode)
          OP_R:              state_next = ST_EX_R;
          OP_I:              state_next = ST_EX_I;
          OP_LOAD, OP_STORE: state_next = ST_EX_ADDR;
          OP_BR:             state_next = ST_EX_BR;
          OP_JAL:            state_next = ST_EX_JAL;
          OP_JALR:           state_next = ST_EX_JALR;
          OP_SYS:            state_next = ST_EX_ECALL;
          default:           state_next = ST_PC4;
        endcase
      end
      ST_EX_R, ST_EX_I: state_next = ST_WB_ALU;
      ST_EX_ADDR:       state_next = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:        state_next = ST_WB_LD;
      ST_EX_BR:         state_next = bcond ? ST_BR_T : ST_PC4;
      ST_EX_ECALL:      state_next = halt_req ? ST_HALT : ST_IF;
      ST_HALT:          state_next = ST_HALT;
      default:          state_next = ST_IF;
    endcase
  end

  // Moore decode of the current state; only EX_ECALL looks at an input (halt_req).
  // Reset masks every enable so nothing is written while the machine is held.
  always_comb begin
    pc_write  = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALUOUT;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REG;
    alu_op    = ALUOP_ADD;
    pc_source = PCSRC_ALU;
    retire    = 1'b0;
    is_halted = 1'b0;

    case (state)
      ST_IF: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
      end
      ST_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYP;
      end
      ST_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ITYP;
      end
      ST_EX_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WR, ST_WB_ALU, ST_WB_LD, ST_PC4: begin
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        retire    = 1'b1;
        if (state == ST_MEM_WR) begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        if (state == ST_WB_ALU) reg_write = 1'b1;
        if (state == ST_WB_LD) begin
          reg_write = 1'b1;
          wb_sel    = WB_MDR;
        end
      end
      ST_EX_BR: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_BR;
      end
      ST_BR_T: begin
        alu_src_b = SRCB_IMM;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      ST_EX_JAL, ST_EX_JALR: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC4;
        alu_src_b = SRCB_IMM;
        pc_write  = 1'b1;
        retire    = 1'b1;
        if (state == ST_EX_JALR) begin
          alu_src_a = 1'b1;
          pc_source = PCSRC_JALR;
        end
      end
      ST_EX_ECALL: begin
        alu_src_b = SRCB_FOUR;
        pc_write  = ~halt_req;
        retire    = 1'b1;
      end
      ST_HALT: is_halted = 1'b1;
      default: ;
    endcase

    if (reset) begin
      pc_write  = 1'b0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
      is_halted = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       inst_count <= 32'd0;
    else if (retire) inst_count <= inst_count + 32'd1;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control FSM for the RV32I multi-cycle CPU. It sits directly upstream of the datapath select muxes: its 2-bit `alu_src_b` and `pc_source` outputs drive the `cond` inputs of the 4:1 operand and next-PC muxes. It also produces every datapath write enable, a halt flag, and a retired-instruction counter. Outputs are Moore-decoded from the current state, except where noted.

## Interface
- No parameters; state encoding is fixed at 4 bits, 16 states.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 7: instruction register bits [6:0].
- `bcond` in 1: branch-condition result from the ALU, valid in EX_BR.
- `halt_req` in 1: high when x17 == 10; sampled in EX_ECALL.
- `pc_write` out 1: PC register write enable.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `ir_write` out 1: instruction register write enable.
- `reg_write` out 1: register file write enable.
- `wb_sel` out 2: write-back select; 00 = ALUOut, 01 = MDR, 10 = PC+4 (dedicated adder).
- `alu_src_a` out 1: 0 = PC, 1 = A register (rs1).
- `alu_src_b` out 2: 00 = B register (rs2), 01 = constant 4, 10 = immediate, 11 = unused (never driven).
- `alu_op` out 2: 00 = add, 01 = branch compare (funct3), 10 = R-type funct decode, 11 = I-type funct decode.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut register, 10 = ALU result & ~1, 11 = unused (never driven).
- `retire` out 1: high during the final cycle of each instruction.
- `is_halted` out 1: high in HALT.
- `inst_count` out 32: retired-instruction count.

## Operation
- The states, in the order below, are: IF, ID, EX_R, EX_I, EX_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_LD, EX_BR, BR_T, PC4, EX_JAL, EX_JALR, EX_ECALL, HALT.
- **Defaults:** every enable is 0. `wb_sel`, `alu_src_b`, `alu_op` and `pc_source` are 00. `alu_src_a` is 0.
- **IF:**
  - Outputs: `mem_read=1`, `i_or_d=0`, `ir_write=1`.
  - Next state: ID.
- **ID:**
  - Registers A and B latch in the datapath.
  - Next state by opcode:
    - 0110011 → EX_R
    - 0010011 → EX_I
    - 0000011 or 0100011 → EX_ADDR
    - 1100011 → EX_BR
    - 1101111 → EX_JAL
    - 1100111 → EX_JALR
    - 1110011 → EX_ECALL
    - any other value → PC4 (executes as a NOP)
- **EX_R:** `alu_src_a=1`, `alu_src_b=00`, `alu_op=10`; next state WB_ALU.
- **EX_I:** `alu_src_a=1`, `alu_src_b=10`, `alu_op=11`; next state WB_ALU.
- **EX_ADDR:**
  - Outputs: `alu_src_a=1`, `alu_src_b=10`, `alu_op=00`.
  - Next state: MEM_RD if opcode is 0000011, otherwise MEM_WR.
- **MEM_RD:** `mem_read=1`, `i_or_d=1`; next state WB_LD.
- **PC+4 update group:** every state in this group drives `alu_src_a=0`, `alu_src_b=01`, `alu_op=00`, `pc_source=00`, `pc_write=1`, `retire=1`. Next state is IF unless stated otherwise.
  - MEM_WR: adds `mem_write=1`, `i_or_d=1`.
  - WB_ALU: adds `reg_write=1`, `wb_sel=00`.
  - WB_LD: adds `reg_write=1`, `wb_sel=01`.
  - PC4: no additional outputs.
- **EX_BR:**
  - Outputs: `alu_src_a=1`, `alu_src_b=00`, `alu_op=01`.
  - Next state: BR_T if `bcond=1`, otherwise PC4.
- **BR_T:**
  - Outputs: `alu_src_a=0`, `alu_src_b=10`, `alu_op=00`, `pc_source=00`, `pc_write=1`, `retire=1`.
  - Next state: IF.
- **EX_JAL:**
  - Outputs: `reg_write=1`, `wb_sel=10`, `alu_src_a=0`, `alu_src_b=10`, `pc_source=00`, `pc_write=1`, `retire=1`.
  - Next state: IF.
- **EX_JALR:** same as EX_JAL, except `alu_src_a=1` and `pc_source=10`; next state IF.
- **EX_ECALL:**
  - Outputs: `retire=1`; PC+4 datapath selects as in the update group.
  - This is the one Mealy output: `pc_write = ~halt_req`.
  - Next state: HALT if `halt_req=1`, otherwise IF.
- **HALT:**
  - Outputs: `is_halted=1`; all enables 0.
  - Stays in HALT until `reset`.
- **Illegal state encodings:** none exist (all 16 encodings are used).
- **Counter:**
  - `inst_count` increments by 1 on each rising edge where `retire=1`.
  - It wraps from 0xFFFFFFFF to 0.

## Timing
- **Reset:**
  - On `reset` assertion, state goes to IF and `inst_count` goes to 0 immediately (asynchronous).
  - While `reset` is high, `pc_write`, `ir_write`, `reg_write`, `mem_write`, `mem_read`, `retire` and `is_halted` are forced to 0. All selects stay at the IF/default values.
  - The first rising edge after `reset` deasserts performs the IF cycle.
  - Reset asserted mid-instruction or in HALT aborts to IF with no retire.
- **Cycles per instruction:**
  - R-type, I-type ALU, SW, branch: 4.
  - LW: 5.
  - JAL, JALR, ECALL, unknown opcode: 3.
- **Retire timing:** `retire` is high for exactly one cycle per instruction, always the last cycle. The HALT state never retires.
- **Sampling:** `bcond` is sampled only at the EX_BR→next edge, and `halt_req` only in EX_ECALL. Both are ignored elsewhere.

## Test plan
- **Reset:** assert `reset` mid-EX_R → state is IF and `inst_count`=0 immediately; after release, IF outputs `mem_read=1`, `ir_write=1`.
- **R and LW sequence:** opcode 0110011, then 0000011 → states IF,ID,EX_R,WB_ALU, then IF,ID,EX_ADDR,MEM_RD,WB_LD; `wb_sel` 00 then 01; `inst_count`=2 after 9 cycles.
- **Branch:** opcode 1100011 with `bcond=1` → BR_T with `alu_src_b=10`, `pc_write=1`. With `bcond=0` → PC4 with `alu_src_b=01`. Each takes 4 cycles.
- **Jumps:** JALR → EX_JALR drives `pc_source=10`, `wb_sel=10`, `reg_write=1`. JAL drives `pc_source=00`. Each takes 3 cycles.
- **ECALL:** `halt_req=0` → `pc_write=1`, back to IF. `halt_req=1` → `pc_write=0`, then HALT with `is_halted=1`, held for 20 cycles with no enables.
- **Unknown opcode and counter wrap:** opcode 0000000 → IF,ID,PC4 with `retire`. Preload `inst_count` to 0xFFFFFFFF via a forced count → wraps to 0 on the next retire.
